// File: rtl/memc_drain.sv
// memc_drain: output-side drain for the DIM x DIM systolic array.
// Deskews the diagonally skewed result lanes, captures DIM aligned rows into
// a result buffer, then holds the buffer for row-addressed host reads until
// the host releases it.
// Optional build macro: MEMC_ALIGN_CHK_EN adds the sticky align_err output.
// The host release input is named release_req because "release" is a
// reserved word in SystemVerilog.
module memc_drain #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  input  logic [DIM-1:0]                Cvalid,
  input  logic                          rd_en,
  input  logic [$clog2(DIM)-1:0]        rd_row,
  input  logic                          release_req,
  output logic [DIM-1:0][BITS_C-1:0]    rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic [$clog2(DIM):0]          row_cnt,
  output logic                          ovf_err,
`ifdef MEMC_ALIGN_CHK_EN
  output logic                          align_err,
`endif
  output logic                          state_dbg
);

  // Read handshake: rd_en is a single-cycle request sampled at a clk edge
  // while the buffer is held; the matching row appears on rd_data with
  // rd_valid=1 in the following cycle. There is no back-pressure. Requests
  // outside HOLD are dropped and rd_data keeps its last value.

  localparam int AW = $clog2(DIM);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Elements are two's-complement values carried bit-exact; no arithmetic.
  logic [DIM-1:0][BITS_C-1:0] al_data;
  logic [DIM-1:0]             al_v;
  logic [DIM-1:0][BITS_C-1:0] mem [DIM];

  logic [CW-1:0]              cnt_nxt;
  logic                       ovf_nxt;
  logic                       wr_en;
  logic                       rdv_nxt;
  logic [DIM-1:0][BITS_C-1:0] rdd_nxt;
  logic [DIM-1:0][BITS_C-1:0] rd_sel;

  // Per-lane deskew: lane x is delayed DIM-1-x en-cycles so every lane of a
  // row lines up with the (undelayed) last lane.
  for (genvar x = 0; x < DIM; x++) begin : g_lane
    localparam int D = DIM - 1 - x;
    if (D == 0) begin : g_pass
      assign al_data[x] = Cin[x];
      assign al_v[x]    = Cvalid[x];
    end else begin : g_dly
      logic [BITS_C-1:0] sd [D];
      logic [D-1:0]      sv;
      // Shift register for data and valid, advancing only on en.
      always_ff @(posedge clk) begin
        if (rst) begin
          sv <= '0;
          for (int k = 0; k < D; k++) sd[k] <= '0;
        end else if (en) begin
          sd[0] <= Cin[x];
          sv[0] <= Cvalid[x];
          for (int k = 1; k < D; k++) begin
            sd[k] <= sd[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end
      assign al_data[x] = sd[D-1];
      assign al_v[x]    = sv[D-1];
    end
  end

  // Read mux; addresses beyond the buffer return zero.
  always_comb begin
    rd_sel = '0;
    if (int'(rd_row) < DIM) rd_sel = mem[rd_row];
  end

  // Next-state, row counter, overflow and read-return logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = row_cnt;
    ovf_nxt   = ovf_err;
    wr_en     = 1'b0;
    rdv_nxt   = 1'b0;
    rdd_nxt   = rd_data;
    case (state)
      CAPTURE: begin
        if (en && al_v[0]) begin
          wr_en   = 1'b1;
          cnt_nxt = row_cnt + CW'(1);
          if (row_cnt == LAST_ROW) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (en && al_v[0]) ovf_nxt = 1'b1;
        if (rd_en) begin
          rdv_nxt = 1'b1;
          rdd_nxt = rd_sel;
        end
        if (release_req) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CAPTURE;
    endcase
  end

  // Control and read-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CAPTURE;
      row_cnt  <= '0;
      ovf_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      row_cnt  <= cnt_nxt;
      ovf_err  <= ovf_nxt;
      rd_valid <= rdv_nxt;
      rd_data  <= rdd_nxt;
    end
  end

  // Result buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[row_cnt[AW-1:0]] <= al_data;
  end

  assign full      = (state == HOLD);
  assign state_dbg = state;

`ifdef MEMC_ALIGN_CHK_EN
  // Sticky skew check: every lane's delayed valid must match lane 0's.
  always_ff @(posedge clk) begin
    if (rst) align_err <= 1'b0;
    else if (en && (al_v != {DIM{al_v[0]}})) align_err <= 1'b1;
  end
`endif

endmodule

// File: doc/memc_drain.md
Name: memc_drain

Overview:
Output-side companion to the A/B skew loaders. It captures the diagonally skewed result stream leaving the bottom of the DIM x DIM systolic array. Each lane is deskewed by a per-column delay line, and every aligned row is written into a DIM-row result buffer. Once all DIM rows are captured, the buffer is held and row-addressable reads are served to the host/MMIO side until the host releases it.

Parameters:
BITS_C, 24, width of one result element (signed).
DIM, 8, array dimension: lanes per row and rows per tile.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
en  in  1  global advance; deskew delay lines shift only when en=1.
Cin  in  BITS_C x DIM  skewed result lanes (signed); lane x carries column x.
Cvalid  in  DIM  per-lane valid, skewed identically to Cin.
rd_en  in  1  read request.
rd_row  in  clog2(DIM)  row address to read.
release  in  1  pulse: host finished with the tile; return to capture.
rd_data  out  BITS_C x DIM  row read data (signed).
rd_valid  out  1  rd_data valid.
full  out  1  all DIM rows captured; buffer held.
row_cnt  out  clog2(DIM)+1  rows captured so far in the current tile.
ovf_err  out  1  sticky: a valid row arrived while the block was in HOLD.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All delay-line stages and their valid bits clear to 0.
  - rd_data=0, rd_valid=0, full=0, row_cnt=0, ovf_err=0.
  - State=CAPTURE.
  - Buffer contents are don't-care.
  - A reset mid-tile discards the partial tile.
- Deskew:
  - Lane x passes through a DIM-1-x stage register delay, data and valid together.
  - Lane DIM-1 has zero delay; lane 0 has DIM-1 stages.
  - Stages shift only when en=1. With en=0 they hold and no row write occurs.
- Aligned row:
  - aligned_valid = delayed valid of lane 0.
  - Row r is aligned in the cycle its lane DIM-1 element is presented (lane 0 presented DIM-1 en-cycles earlier).
- State CAPTURE:
  - When en=1 and aligned_valid=1, the aligned row is written to buffer[row_cnt] at that edge, and row_cnt increments.
  - When row_cnt goes from DIM-1 to DIM, the next state is HOLD and full=1 from the following cycle.
- State HOLD:
  - Buffer is frozen and row_cnt stays at DIM.
  - An aligned_valid=1 (with en=1) does not write and sets ovf_err.
  - On release=1: next state CAPTURE, row_cnt=0, full=0. ovf_err is not cleared (only rst clears it).
- release in CAPTURE is ignored.
- Reads:
  - Allowed only in HOLD.
  - rd_en=1 at edge t gives rd_data=buffer[rd_row] and rd_valid=1 at t+1; otherwise rd_valid=0 and rd_data holds.
  - rd_en in CAPTURE is ignored (rd_valid=0).
  - rd_row >= DIM (non-power-of-2 DIM only) returns 0 with rd_valid=1.
- Simultaneous events:
  - release and rd_en in the same HOLD cycle: the read is served (one cycle latency, old data) and the state leaves HOLD.
  - In the cycle after release, a row may be captured into row 0.
- Arithmetic: no arithmetic on data. Elements pass bit-exact and signed.

Optional Feature:
MEMC_ALIGN_CHK_EN
- Defined:
  - Adds output align_err (sticky, reset 0).
  - Sets align_err when, with en=1, any lane's delayed valid differs from lane 0's delayed valid, meaning the skew was broken.
  - The row is still written if aligned_valid=1.
- Not defined: no align_err port and no comparison logic.

Test Plan:
- DIM=4, BITS_C=8: feed rows r=0..3 with Cin[x]=16*r+x, skewed so lane x appears r+x cycles after start, en=1 -> row_cnt 1,2,3,4 after each row's lane-3 cycle, full=1 the next cycle; reads of rows 0..3 return {0,1,2,3},{16,..,19},{32,..,35},{48,..,51}, each with rd_valid one cycle after rd_en.
- Same stimulus with en=0 asserted for 2 cycles mid-stream (inputs held) -> identical buffer contents, full asserted 2 cycles later.
- In HOLD, inject one more skewed row -> ovf_err=1 and the buffer is unchanged (row 0 still reads {0,1,2,3}); release -> full=0, row_cnt=0, ovf_err still 1.
- Negative values: Cin=-1 (0xFF) on all lanes of row 2 -> read row 2 returns 0xFF x4; rd_en in CAPTURE -> rd_valid=0.
- Assert rst after 2 rows captured -> row_cnt=0, full=0, no stale valids emerge from the delay lines; the next 4 rows fill the tile correctly.
- MEMC_ALIGN_CHK_EN defined: drop Cvalid[2] for one element of row 1 -> align_err=1 and stays sticky until rst.
